au_norm_serial: RTL and testbench

Iterative left-normalizer. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it left until its MSB is 1, moving at most STEP bits per cycle. It returns the normalized word, the total shift count, and a no-detect flag for zero input. It sits downstream of the leading-one detection logic in the arithmetic unit library: it consumes the same leading-one information that AU_lead_zero_det produces and applies it, as used in floating-point mantissa normalization.

---
 rtl/au_norm_pkg.sv | 10 +
 rtl/au_norm_serial_lzd.sv | 27 ++
 rtl/au_norm_serial.sv | 109 ++++++++++
 tb/tb_au_norm_serial.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/au_norm_pkg.sv
// Shared types and helpers for the iterative left-normalizer.
package au_norm_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} au_norm_state_t;

  function automatic int au_norm_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/au_norm_serial_lzd.sv
// Leading-one detector: one-hot flag on the most significant set bit of a,
// plus a no-detect flag when a is all zeros.
module AU_lead_zero_det #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] z,
  output logic             no_det
);

  logic w_found;

  // Scan from the MSB down so only the first set bit is flagged.
  always_comb begin
    z       = '0;
    w_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (a[i] && !w_found) begin
        z[i]    = 1'b1;
        w_found = 1'b1;
      end
    end
  end

  assign no_det = ~|a;

endmodule

// File: rtl/au_norm_serial.sv
// Iterative left-normalizer: shifts a word left by up to STEP bits per cycle
// until its MSB is set, reporting the total shift and a zero-input flag.
module au_norm_serial
  import au_norm_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int STEP  = 4,
  localparam int CNTW  = au_norm_cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic [CNTW-1:0]  cnt,
  output logic             no_det
);

  au_norm_state_t   r_state;
  logic [WIDTH-1:0] r_work;
  logic [CNTW-1:0]  r_cnt;
  logic             r_noDet;
  logic             r_outValid;

  logic [STEP-1:0]  w_window;
  logic [STEP-1:0]  w_oneHot;
  logic             w_lzdNoDet;
  logic [CNTW-1:0]  w_encoded;
  logic [CNTW-1:0]  w_k;

  assign w_window = r_work[WIDTH-1 -: STEP];

  AU_lead_zero_det #(
    .WIDTH (STEP)
  ) u_lzd (
    .a      (w_window),
    .z      (w_oneHot),
    .no_det (w_lzdNoDet)
  );

  // A one at window position i means STEP-1-i zeros sit above it.
  always_comb begin
    w_encoded = '0;
    for (int i = 0; i < STEP; i++) begin
      if (w_oneHot[i]) begin
        w_encoded = CNTW'(STEP - 1 - i);
      end
    end
    w_k = w_lzdNoDet ? CNTW'(STEP) : w_encoded;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_work     <= '0;
      r_cnt      <= '0;
      r_noDet    <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work  <= a;
            r_cnt   <= '0;
            r_noDet <= 1'b0;
            if (a == '0) begin
              r_noDet    <= 1'b1;
              r_cnt      <= CNTW'(WIDTH);
              r_outValid <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_work <= r_work << w_k;
          r_cnt  <= r_cnt + w_k;
          // A short shift means a one reached the MSB.
          if (w_k != CNTW'(STEP)) begin
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_outValid <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  // Gated by rst so the block never advertises readiness during reset.
  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = r_outValid;
  assign z         = r_work;
  assign cnt       = r_cnt;
  assign no_det    = r_noDet;

endmodule

// File: tb/tb_au_norm_serial.sv
// Directed and randomized self-checking bench for au_norm_serial (WIDTH=16, STEP=4).
module tb_au_norm_serial;

  localparam int WIDTH = 16;
  localparam int STEP  = 4;
  localparam int CNTW  = 5;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic [CNTW-1:0]  cnt;
  logic             no_det;

  int total;
  int bad;

  au_norm_serial #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .cnt       (cnt),
    .no_det    (no_det)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one word, counts edges until out_valid, captures the result
  // and then drains it with a single out_ready pulse.
  task automatic runWord(input logic [WIDTH-1:0] word,
                         output logic [WIDTH-1:0] gotZ,
                         output logic [CNTW-1:0] gotCnt,
                         output logic gotNoDet,
                         output int lat,
                         output logic timedOut);
    int waitCycles;
    timedOut   = 1'b0;
    lat        = 0;
    waitCycles = 0;
    @(negedge clk);
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      timedOut = 1'b1;
      return;
    end
    in_valid = 1'b1;
    a        = word;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      timedOut = 1'b1;
      return;
    end
    gotZ     = z;
    gotCnt   = cnt;
    gotNoDet = no_det;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
    end
    total++;
    if (z !== 16'h0000 || cnt !== 5'd0 || no_det !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got z=%h cnt=%0d no_det=%b want z=0000 cnt=0 no_det=0",
               z, cnt, no_det);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] vecA    [5] = '{16'h8000, 16'h0001, 16'h0C00, 16'h1234, 16'h0000};
    logic [WIDTH-1:0] vecZ    [5] = '{16'h8000, 16'h8000, 16'hC000, 16'h91A0, 16'h0000};
    logic [CNTW-1:0]  vecCnt  [5] = '{5'd0, 5'd15, 5'd4, 5'd3, 5'd16};
    logic             vecNd   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int               vecLat  [5] = '{1, 4, 2, 1, 0};
    logic [WIDTH-1:0] gotZ;
    logic [CNTW-1:0]  gotCnt;
    logic             gotNd;
    int               lat;
    logic             timedOut;
    for (int i = 0; i < 5; i++) begin
      runWord(vecA[i], gotZ, gotCnt, gotNd, lat, timedOut);
      total++;
      if (timedOut) begin
        bad++;
        $display("[TB] FAIL directed_timeout a=%h: got no result want result", vecA[i]);
        continue;
      end
      if (gotZ !== vecZ[i]) begin
        bad++;
        $display("[TB] FAIL directed_z a=%h: got %h want %h", vecA[i], gotZ, vecZ[i]);
      end
      total++;
      if (gotCnt !== vecCnt[i]) begin
        bad++;
        $display("[TB] FAIL directed_cnt a=%h: got %0d want %0d", vecA[i], gotCnt, vecCnt[i]);
      end
      total++;
      if (gotNd !== vecNd[i]) begin
        bad++;
        $display("[TB] FAIL directed_no_det a=%h: got %b want %b", vecA[i], gotNd, vecNd[i]);
      end
      total++;
      if (lat != vecLat[i]) begin
        bad++;
        $display("[TB] FAIL directed_latency a=%h: got %0d want %0d", vecA[i], lat, vecLat[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int               lat;
    logic [WIDTH-1:0] gotZ;
    logic [CNTW-1:0]  gotCnt;
    logic             gotNd;
    logic             timedOut;
    @(negedge clk);
    in_valid = 1'b1;
    a        = 16'h00F0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (!out_valid || lat != 3) begin
      bad++;
      $display("[TB] FAIL bp_latency: got valid=%b lat=%0d want valid=1 lat=3", out_valid, lat);
    end
    // Offer a competing word while the result is stalled.
    in_valid = 1'b1;
    a        = 16'h0001;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || z !== 16'hF000 || cnt !== 5'd8 || no_det !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bp_hold cycle %0d: got v=%b z=%h cnt=%0d nd=%b want v=1 z=f000 cnt=8 nd=0",
                 c, out_valid, z, cnt, no_det);
      end
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bp_in_ready cycle %0d: got %b want 0", c, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    runWord(16'h4000, gotZ, gotCnt, gotNd, lat, timedOut);
    total++;
    if (timedOut || gotZ !== 16'h8000 || gotCnt !== 5'd1 || lat != 1) begin
      bad++;
      $display("[TB] FAIL bp_next_word: got to=%b z=%h cnt=%0d lat=%0d want to=0 z=8000 cnt=1 lat=1",
               timedOut, gotZ, gotCnt, lat);
    end
  endtask

  task automatic test_reset_in_shift();
    logic sawValid;
    sawValid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    a        = 16'h0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (out_valid) sawValid = 1'b1;
    @(posedge clk);
    #1;
    if (out_valid) sawValid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    if (out_valid) sawValid = 1'b1;
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_shift_in_ready: got %b want 1", in_ready);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) sawValid = 1'b1;
    end
    total++;
    if (sawValid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_shift_out_valid: got %b want 0", sawValid);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] expZ;
    int               expCnt;
    int               expLat;
    logic [WIDTH-1:0] gotZ;
    logic [CNTW-1:0]  gotCnt;
    logic             gotNd;
    int               lat;
    logic             timedOut;
    int               lz;
    for (int n = 0; n < 10000; n++) begin
      word = WIDTH'($urandom) >> $urandom_range(0, WIDTH);
      lz = 0;
      while (lz < WIDTH && word[WIDTH-1-lz] == 1'b0) lz++;
      if (lz == WIDTH) begin
        expZ   = '0;
        expCnt = WIDTH;
        expLat = 0;
      end else begin
        expZ   = word << lz;
        expCnt = lz;
        expLat = lz / STEP + 1;
      end
      runWord(word, gotZ, gotCnt, gotNd, lat, timedOut);
      total++;
      if (timedOut || gotZ !== expZ || int'(gotCnt) != expCnt || lat != expLat
          || gotNd !== (lz == WIDTH)) begin
        bad++;
        $display("[TB] FAIL random a=%h: got to=%b z=%h cnt=%0d nd=%b lat=%0d want z=%h cnt=%0d lat=%0d",
                 word, timedOut, gotZ, gotCnt, gotNd, lat, expZ, expCnt, expLat);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_in_shift();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
